// File: rtl/tiny_mcu_pkg.sv
// Shared fetch-unit types and default sizing for the tiny MCU front end.
package tiny_mcu_pkg;

  localparam int unsigned DEF_ADDR_W    = 5;
  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_ROM_DEPTH = 16;
  localparam int unsigned FIFO_DEPTH    = 2;
  localparam int unsigned FIFO_CNT_W    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/tiny_fetch_fifo.sv
// Two-entry shift-style instruction buffer; entry 0 is always the head.
module tiny_fetch_fifo
  import tiny_mcu_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_W-1:0]     push_data,
  input  logic [ADDR_W-1:0]     push_addr,
  input  logic                  pop,
  output logic [FIFO_CNT_W-1:0] count,
  output logic                  valid,
  output logic [DATA_W-1:0]     head_data,
  output logic [ADDR_W-1:0]     head_addr
);

  localparam int unsigned ENTRY_W = DATA_W + ADDR_W;

  logic [ENTRY_W-1:0]    e0_q, e1_q, e0_d, e1_d, in_entry;
  logic [FIFO_CNT_W-1:0] count_d;
  logic                  pop_ok, push_ok;

  always_comb begin
    in_entry = {push_data, push_addr};
    e0_d     = e0_q;
    e1_d     = e1_q;
    count_d  = count;
    pop_ok   = pop && (count != '0);
    push_ok  = push && ((count < FIFO_CNT_W'(FIFO_DEPTH)) || pop_ok);
    case ({pop_ok, push_ok})
      2'b01: begin
        if (count == '0) e0_d = in_entry;
        else             e1_d = in_entry;
        count_d = count + FIFO_CNT_W'(1);
      end
      2'b10: begin
        e0_d    = e1_q;
        count_d = count - FIFO_CNT_W'(1);
      end
      2'b11: begin
        if (count == FIFO_CNT_W'(1)) begin
          e0_d = in_entry;
        end else begin
          e0_d = e1_q;
          e1_d = in_entry;
        end
      end
      default: ;
    endcase
  end

  // Flush drops occupancy only; stale payload is hidden behind valid=0.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      valid <= 1'b0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else if (flush) begin
      count <= '0;
      valid <= 1'b0;
    end else begin
      count <= count_d;
      valid <= (count_d != '0);
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end

  assign {head_data, head_addr} = e0_q;

endmodule

// File: rtl/tiny_fetch_unit.sv
// Sequential instruction fetch from a one-cycle-latency ROM with jump redirect
// and a credit-limited two-entry delivery buffer.
module tiny_fetch_unit
  import tiny_mcu_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ROM_DEPTH = DEF_ROM_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] readAddress,
  input  logic [DATA_W-1:0] dataout,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              fetch_err
);

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(ROM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(ROM_DEPTH - 1);

  fetch_state_t          state_q, state_d;
  logic [ADDR_W-1:0]     pc_q, pc_d, raddr_d;
  logic                  inflight_q, inflight_d, err_d;
  logic                  jump_ok, jump_bad, pop, issue, credit;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [FIFO_CNT_W:0]   occupancy;

  assign pop       = instr_valid && instr_ready;
  assign jump_bad  = jump_valid && ({1'b0, jump_target} >= DEPTH_X);
  assign jump_ok   = jump_valid && ({1'b0, jump_target} < DEPTH_X);
  // Slots claimed once this cycle settles: buffered, minus leaving, plus arriving.
  assign occupancy = (FIFO_CNT_W+1)'(fifo_count) + (FIFO_CNT_W+1)'(inflight_q)
                   - (FIFO_CNT_W+1)'(pop);
  assign credit    = occupancy < (FIFO_CNT_W+1)'(FIFO_DEPTH);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    raddr_d    = readAddress;
    inflight_d = 1'b0;
    err_d      = fetch_err;
    issue      = 1'b0;
    case (state_q)
      IDLE: if (enable) state_d = RUN;
      RUN: begin
        if (!enable) state_d = IDLE;
        issue = enable && credit && !jump_valid;
      end
      HALT: ;
      default: state_d = IDLE;
    endcase
    if (issue) begin
      raddr_d    = pc_q;
      pc_d       = (pc_q == LAST_PC) ? '0 : pc_q + ADDR_W'(1);
      inflight_d = 1'b1;
    end
    if (jump_ok && (state_q != HALT)) pc_d = jump_target;
    if (jump_bad) begin
      state_d = HALT;
      err_d   = 1'b1;
    end
  end

  // A jump of any kind discards the in-flight word along with the buffer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      readAddress <= '0;
      inflight_q  <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      readAddress <= raddr_d;
      inflight_q  <= inflight_d && !jump_valid;
      fetch_err   <= err_d;
    end
  end

  tiny_fetch_fifo #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .flush    (jump_valid),
    .push     (inflight_q),
    .push_data(dataout),
    .push_addr(readAddress),
    .pop      (pop),
    .count    (fifo_count),
    .valid    (instr_valid),
    .head_data(instr_data),
    .head_addr(instr_addr)
  );

endmodule

// File: tb/tb_tiny_fetch_unit.sv
// Bench for tiny_fetch_unit: cycle-vector table plus scoreboarded stall/enable/reset sequences.
module tb_tiny_fetch_unit;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;

  logic          clock = 1'b0;
  logic          reset, enable, jump_valid, instr_ready;
  logic [AW-1:0] jump_target, readAddress, instr_addr;
  logic [DW-1:0] dataout, instr_data;
  logic          instr_valid, fetch_err;
  logic [DW-1:0] rom [32];

  int checks = 0;
  int errors = 0;
  bit sb_on  = 1'b0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic          rst, en, jv;
    logic [AW-1:0] jt;
    logic          rdy, ev;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          eerr;
  } vec_t;
  vec_t vecs[$];

  always #5 clock = ~clock;

  assign dataout = rom[readAddress];

  tiny_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .ROM_DEPTH(16)) u_dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .readAddress(readAddress),
    .dataout    (dataout),
    .jump_valid (jump_valid),
    .jump_target(jump_target),
    .instr_data (instr_data),
    .instr_addr (instr_addr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .fetch_err  (fetch_err)
  );

  function automatic logic [DW-1:0] rom_val(input int a);
    if (a <= 13)  return DW'(a);
    if (a == 14)  return 8'h0F;
    if (a == 15)  return 8'h10;
    return 8'hEE;
  endfunction

  function automatic vec_t mk(input logic rst, en, jv, input int jt, input logic rdy, ev,
                              input int ea, input logic eerr);
    vec_t v;
    v.rst = rst; v.en = en; v.jv = jv; v.jt = AW'(jt); v.rdy = rdy;
    v.ev = ev; v.ea = AW'(ea); v.ed = rst ? '0 : rom_val(ea); v.eerr = eerr;
    return v;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic push_exp(input int lo, input int hi);
    exp_t e;
    for (int a = lo; a <= hi; a++) begin
      e.a = AW'(a);
      e.d = rom_val(a);
      sbq.push_back(e);
    end
  endtask

  task automatic wait_raddr(input int a, input string name);
    int n = 0;
    while (readAddress !== AW'(a) && n < 30) begin
      step();
      n++;
    end
    chk(name, 32'(readAddress), 32'(a));
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; jump_valid = 1'b0; jump_target = '0; instr_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Scoreboard: a transfer happens at the next rising edge when valid&&ready here.
  always @(negedge clock) begin
    if (sb_on && instr_valid && instr_ready) begin
      exp_t e;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_extra got addr=%0d data=%0h want none", instr_addr, instr_data);
      end else begin
        e = sbq.pop_front();
        if (instr_addr !== e.a || instr_data !== e.d) begin
          errors++;
          $display("FAIL sb_xfer got addr=%0d data=%0h want addr=%0d data=%0h",
                   instr_addr, instr_data, e.a, e.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 32; i++) rom[i] = rom_val(i);

    // Reset, streaming start and wrap, in-range jump, out-of-range jump, reset over enable.
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0));
    for (int a = 0; a < 16; a++) vecs.push_back(mk(0, 1, 0, 0, 1, 1, a, 0));
    for (int a = 0; a < 4; a++)  vecs.push_back(mk(0, 1, 0, 0, 1, 1, a, 0));
    vecs.push_back(mk(0, 1, 1, 9, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 9, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 10, 0));
    vecs.push_back(mk(0, 1, 1, 20, 1, 0, 0, 1));
    for (int k = 0; k < 4; k++) vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; enable = vecs[i].en; jump_valid = vecs[i].jv;
      jump_target = vecs[i].jt; instr_ready = vecs[i].rdy;
      step();
      chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].ev));
      chk($sformatf("v%0d_err", i), 32'(fetch_err), 32'(vecs[i].eerr));
      if (vecs[i].ev || vecs[i].rst) begin
        chk($sformatf("v%0d_addr", i), 32'(instr_addr), 32'(vecs[i].ea));
        chk($sformatf("v%0d_data", i), 32'(instr_data), 32'(vecs[i].ed));
      end
      if (vecs[i].rst) chk($sformatf("v%0d_raddr", i), 32'(readAddress), 32'd0);
    end

    // Stall for 5 cycles mid-stream, then stop after address 5, then resume at 6.
    do_reset();
    sbq.delete();
    push_exp(0, 5);
    sb_on  = 1'b1;
    enable = 1'b1;
    n = 0;
    while (!(instr_valid && instr_addr == AW'(2)) && n < 20) begin
      step();
      n++;
    end
    chk("stall_reach", 32'(instr_addr), 32'd2);
    instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_valid", 32'(instr_valid), 32'd1);
      if (sbq.size() != 0) begin
        chk("stall_addr", 32'(instr_addr), 32'(sbq[0].a));
        chk("stall_data", 32'(instr_data), 32'(sbq[0].d));
      end else begin
        chk("stall_queue", 32'(sbq.size()), 32'd1);
      end
    end
    chk("stall_no_issue", 32'(readAddress), 32'd3);
    instr_ready = 1'b1;
    wait_raddr(5, "wait_raddr5");
    enable = 1'b0;
    for (int k = 0; k < 6; k++) step();
    chk("drain5_queue", 32'(sbq.size()), 32'd0);
    chk("drain5_raddr", 32'(readAddress), 32'd5);
    chk("drain5_valid", 32'(instr_valid), 32'd0);
    push_exp(6, 9);
    enable = 1'b1;
    wait_raddr(9, "wait_raddr9");
    enable = 1'b0;
    for (int k = 0; k < 6; k++) step();
    chk("drain9_queue", 32'(sbq.size()), 32'd0);
    chk("drain9_raddr", 32'(readAddress), 32'd9);
    sb_on = 1'b0;

    // Reset with two entries buffered and the consumer stalled.
    do_reset();
    instr_ready = 1'b0;
    enable      = 1'b1;
    for (int k = 0; k < 6; k++) step();
    chk("full_valid", 32'(instr_valid), 32'd1);
    chk("full_head", 32'(instr_addr), 32'd0);
    chk("full_raddr", 32'(readAddress), 32'd1);
    reset = 1'b1;
    step();
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_addr", 32'(instr_addr), 32'd0);
    chk("rst_data", 32'(instr_data), 32'd0);
    chk("rst_raddr", 32'(readAddress), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    reset       = 1'b0;
    instr_ready = 1'b1;
    step();
    chk("post_rst_valid", 32'(instr_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tiny_fetch_unit.md
TINY_FETCH_UNIT -- requirements
Module: tiny_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, meaning the program-ROM address width.
REQ-002 SHALL have parameter DATA_W, default 8, meaning the instruction width.
REQ-003 SHALL have parameter ROM_DEPTH, default 16, meaning the number of populated ROM words (addresses 0..ROM_DEPTH-1).
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1 bit: permits issuing new fetches while high.
REQ-007 SHALL have port readAddress, output, ADDR_W bits: the ROM read address, registered.
REQ-008 SHALL have port dataout, input, DATA_W bits: ROM data, valid one cycle after its address.
REQ-009 SHALL have port jump_valid, input, 1 bit, and port jump_target, input, ADDR_W bits: a redirect request.
REQ-010 SHALL have port instr_data, output, DATA_W bits, and port instr_addr, output, ADDR_W bits: the delivered instruction and its address.
REQ-011 SHALL have port instr_valid, output, 1 bit, and port instr_ready, input, 1 bit: the delivery handshake.
REQ-012 SHALL have port fetch_err, output, 1 bit: a sticky out-of-range jump flag.

Function
REQ-013 SHALL implement states IDLE, RUN and HALT: IDLE->RUN when enable=1; RUN->IDLE when enable=0; any state->HALT on an out-of-range jump; HALT is left only by reset.
REQ-014 SHALL issue one address per cycle in RUN when credit permits, driving readAddress=pc and then pc<=pc+1.
REQ-015 SHALL wrap pc from ROM_DEPTH-1 to 0, so no address >= ROM_DEPTH is ever issued by increment.
REQ-016 SHALL track a one-bit in-flight tag plus the issued address, and on the next cycle write {dataout, address} into a 2-entry output FIFO.
REQ-017 SHALL issue only if (fifo_count - pop + inflight) < 2, so the FIFO never overflows and data is never dropped.
REQ-018 SHALL sustain one instruction per cycle with instr_ready held high.
REQ-019 SHALL deliver the first instr_valid exactly 3 cycles after the first cycle with reset=0 and enable=1 (C0: ->RUN; C1: address 0 issued; C2: data captured; C3: valid).
REQ-020 SHALL present the FIFO head on instr_valid, instr_data and instr_addr; a transfer occurs when instr_valid&&instr_ready.
REQ-021 SHALL keep instr_data and instr_addr stable while instr_valid&&!instr_ready.
REQ-022 SHALL, on jump_valid with jump_target<ROM_DEPTH: flush the FIFO, discard any in-flight data, set pc<=jump_target, and issue jump_target the next cycle if in RUN. instr_valid SHALL be 0 the cycle after the jump; the target instruction SHALL appear 3 cycles after the jump cycle.
REQ-023 SHALL count a transfer coinciding with a jump as completed, with the flush applied afterwards.
REQ-024 SHALL, on jump_valid with jump_target>=ROM_DEPTH: set fetch_err<=1, go to HALT, flush the FIFO, and stop issuing.
REQ-025 SHALL, when enable falls: stop issuing new fetches; in-flight and FIFO contents remain deliverable.
REQ-026 SHALL, on a jump while enable=0: update pc without issuing any fetch.

Reset
REQ-027 SHALL, on reset, set state=IDLE, pc=0, readAddress=0, inflight=0, fifo_count=0, instr_valid=0, instr_data=0, instr_addr=0, fetch_err=0.
REQ-028 SHALL, on reset asserted mid-stream, discard all in-flight and buffered data; no instr_valid in the following cycle.
REQ-029 SHALL give reset priority over jump_valid and enable.

Structure
REQ-030 SHALL place the fetch state enum, ADDR_W/DATA_W/ROM_DEPTH defaults and the FIFO depth constant (2) in shared package tiny_mcu_pkg.
REQ-031 SHALL implement the 2-entry output buffer as sub-module tiny_fetch_fifo (synchronous flush, push, pop, count).

Verification
REQ-032 SHALL verify: reset release with enable=1, ready=1, ROM mem[i]=i for i=0..13, mem[14]=0x0F, mem[15]=0x10 -> data 00..0D,0F,10 then 00 (wrap), one per cycle, first at C3.
REQ-033 SHALL verify: ready=0 for 5 cycles mid-stream -> instr_data held stable, at most 2 buffered, no loss or duplication after ready=1.
REQ-034 SHALL verify: jump_target=9 while streaming address 3 -> instr_valid=0 next cycle, then addr 9 data 0x09, then addr 10 data 0x0A.
REQ-035 SHALL verify: jump_target=20 -> fetch_err=1, HALT, no further instr_valid until reset.
REQ-036 SHALL verify: enable low after address 5 issued -> address 5 delivered, no address 6 issued, resume from 6 on enable=1.
REQ-037 SHALL verify: reset asserted with 2 entries buffered -> instr_valid=0 next cycle and all outputs at reset values.
